// File: rtl/alu_mc_if.sv
// alu_mc_if -- request/result bundle for the multi-cycle ALU.
//
// Request side : in_valid, in_ready, op, src1, src2, cancel
// Result side  : out_valid, out_ready, result, result_hi, overflow, busy
//
// master : the execute stage (drives requests, consumes results)
// slave  : the ALU itself
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             cancel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, op, src1, src2, cancel, out_ready,
        input  in_ready, out_valid, result, result_hi, overflow, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, cancel, out_ready,
        output in_ready, out_valid, result, result_hi, overflow, busy
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc -- parametrised multi-cycle integer ALU with valid/ready handshake.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_mc_if.slave
//            in_valid/in_ready/op/src1/src2 : request (accepted on in_valid & in_ready)
//            cancel                         : abandon an in-flight MUL/DIV
//            out_valid/out_ready            : result handshake
//            result/result_hi/overflow      : registered result
//            busy                           : iterative unit running
//
// Ops 0-11 complete on the accept edge. Ops 12-15 (MUL/MULU/DIV/DIVU) run
// one shift-add / restoring-divide step per cycle over operand magnitudes,
// with the sign correction folded into the last step, so the result appears
// WIDTH+1 edges after the accept edge (including the accept edge).
// WIDTH must be one of 8, 16, 32, 64.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg;        // MUL: partial product high; DIV: partial remainder
    logic [WIDTH-1:0] lo_reg;        // MUL: multiplier shifting out; DIV: dividend in / quotient out
    logic [WIDTH-1:0] mag_reg;       // |src2|: multiplicand or divisor
    logic             is_mul_reg;
    logic             neg_q_reg;     // negate product / quotient at the end
    logic             neg_r_reg;     // negate remainder at the end
    logic             div_zero_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             overflow_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic in_ready;
    logic accept;

    // A result in DONE frees the unit in the same cycle it is consumed,
    // which is what allows back-to-back issue.
    assign in_ready = (state_reg == ST_IDLE) ||
                      ((state_reg == ST_DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign a     = bus.src1;
    assign b     = bus.src2;
    assign shamt = a[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_AND:  alu_res = a & b;
            OP_NOR:  alu_res = ~(a | b);
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning for the iterative unit (ops 12-15).
    // op[0]=0 selects the signed variant, op[1]=0 selects multiply.
    // ------------------------------------------------------------------
    logic             is_multi_op;
    logic             op_signed;
    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    assign is_multi_op = (bus.op[3:2] == 2'b11);
    assign op_signed   = !bus.op[0];
    assign neg1        = op_signed && a[WIDTH-1];
    assign neg2        = op_signed && b[WIDTH-1];
    assign mag1        = neg1 ? -a : a;
    assign mag2        = neg2 ? -b : b;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Shift-add: add the multiplicand when the current multiplier LSB is
    // set, then shift the {carry, hi, lo} triple right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mag_reg} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

    // Restoring division: shift the next dividend bit into the remainder
    // and keep the difference when it does not go negative. The partial
    // remainder is always below 2*divisor, so WIDTH+1 bits are enough.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign rem_sh      = {hi_reg, lo_reg[WIDTH-1]};
    assign rem_diff    = rem_sh - {1'b0, mag_reg};
    assign div_ge      = !rem_diff[WIDTH];
    assign div_hi_next = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_lo_next = {lo_reg[WIDTH-2:0], div_ge};

    // Sign correction applied to the outcome of the final step.
    // Divide-by-zero: the step above leaves the dividend magnitude in the
    // remainder, so the sign fix restores src1; only the quotient needs
    // forcing to all ones. MIN / -1 falls out naturally as MIN, rem 0.
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_mag = {mul_hi_next, mul_lo_next};
    assign prod_fix = neg_q_reg ? -prod_mag : prod_mag;
    assign quot_fix = div_zero_reg ? '1 : (neg_q_reg ? -div_lo_next : div_lo_next);
    assign rem_fix  = neg_r_reg ? -div_hi_next : div_hi_next;

    // ------------------------------------------------------------------
    // FSM and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            mag_reg       <= '0;
            is_mul_reg    <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            div_zero_reg  <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // cancel has nothing to abort here
                end
                ST_BUSY: begin
                    if (bus.cancel) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                        hi_reg  <= is_mul_reg ? mul_hi_next : div_hi_next;
                        lo_reg  <= is_mul_reg ? mul_lo_next : div_lo_next;
                        // Counter reaches zero on this edge: commit.
                        if (cnt_reg == CW'(1)) begin
                            state_reg     <= ST_DONE;
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b1;
                            overflow_reg  <= 1'b0;
                            result_reg    <= is_mul_reg ? prod_fix[WIDTH-1:0] : quot_fix;
                            result_hi_reg <= is_mul_reg ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // A new accept (from IDLE, or from DONE during the handshake)
            // overrides the transitions above.
            if (accept) begin
                if (is_multi_op) begin
                    state_reg     <= ST_BUSY;
                    busy_reg      <= 1'b1;
                    out_valid_reg <= 1'b0;
                    cnt_reg       <= CW'(WIDTH);
                    hi_reg        <= '0;
                    lo_reg        <= mag1;
                    mag_reg       <= mag2;
                    is_mul_reg    <= !bus.op[1];
                    neg_q_reg     <= neg1 ^ neg2;
                    neg_r_reg     <= neg1;
                    div_zero_reg  <= (b == '0);
                end else begin
                    state_reg     <= ST_DONE;
                    out_valid_reg <= 1'b1;
                    result_reg    <= alu_res;
                    result_hi_reg <= '0;
                    overflow_reg  <= alu_ovf;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.result_hi = result_hi_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc -- self-checking bench for alu_mc (WIDTH=32 and WIDTH=16 instances).
// Expected values come from a behavioural model using 64-bit integer
// arithmetic, plus hand-derived constants for the directed cases.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) ifc ();
    alu_mc_if #(.WIDTH(16)) ifc16 ();

    alu_mc #(.WIDTH(32)) dut   (.clk(clk), .rst(rst), .bus(ifc));
    alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));

    int checks = 0;
    int errors = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference for WIDTH=32.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi, output logic ov);
        longint sa, sb, s, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lo = '0; hi = '0; ov = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; lo = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
            4'd1: begin s = sa - sb; lo = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
            4'd2: lo = (sa < sb) ? 32'd1 : 32'd0;
            4'd3: lo = (a < b) ? 32'd1 : 32'd0;
            4'd4: lo = a & b;
            4'd5: lo = ~(a | b);
            4'd6: lo = a | b;
            4'd7: lo = a ^ b;
            4'd8: lo = b << a[4:0];
            4'd9: lo = b >> a[4:0];
            4'd10: lo = $signed(b) >>> a[4:0];
            4'd11: lo = {b[15:0], 16'h0000};
            4'd12: begin s = sa * sb; lo = s[31:0]; hi = s[63:32]; end
            4'd13: begin up = {32'h0, a} * {32'h0, b}; lo = up[31:0]; hi = up[63:32]; end
            4'd14: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    // Present a request until accepted (bounded); scramble inputs afterwards
    // so that operand latching is exercised.
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        bit rdy;
        int n;
        ok = 0; n = 0;
        ifc.in_valid = 1'b1; ifc.op = op; ifc.src1 = a; ifc.src2 = b;
        while (!ok && n < 100) begin
            rdy = ifc.in_ready;
            @(posedge clk); #1;
            n++;
            if (rdy) ok = 1;
        end
        ifc.in_valid = 1'b0;
        ifc.op = 4'($urandom);
        ifc.src1 = $urandom;
        ifc.src2 = $urandom;
        check("accept", 64'(ok), 64'(1));
    endtask

    // Edges counted from the accept edge (inclusive) until out_valid.
    task automatic wait_result32(output int lat);
        lat = 1;
        while (!ifc.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_ov);
        int lat;
        int exp_lat;
        exp_lat = (op >= 4'd12) ? 33 : 1;
        issue32(op, a, b);
        wait_result32(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_lo"}, 64'(ifc.result), 64'(exp_lo));
        check({tag, "_hi"}, 64'(ifc.result_hi), 64'(exp_hi));
        check({tag, "_ovf"}, 64'(ifc.overflow), 64'(exp_ov));
        $display("txn %s op=%0d a=%h b=%h lo=%h hi=%h ov=%b lat=%0d", tag, op, a, b,
                 ifc.result, ifc.result_hi, ifc.overflow, lat);
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        check({tag, "_drained"}, 64'(ifc.out_valid), 64'(0));
    endtask

    task automatic run16(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_lo, input logic [15:0] exp_hi, input int exp_lat);
        bit ok;
        bit rdy;
        int n;
        int lat;
        ok = 0; n = 0;
        ifc16.in_valid = 1'b1; ifc16.op = op; ifc16.src1 = a; ifc16.src2 = b;
        while (!ok && n < 100) begin
            rdy = ifc16.in_ready;
            @(posedge clk); #1;
            n++;
            if (rdy) ok = 1;
        end
        ifc16.in_valid = 1'b0;
        ifc16.src1 = 16'($urandom);
        ifc16.src2 = 16'($urandom);
        check({tag, "_accept"}, 64'(ok), 64'(1));
        lat = 1;
        while (!ifc16.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_lo"}, 64'(ifc16.result), 64'(exp_lo));
        check({tag, "_hi"}, 64'(ifc16.result_hi), 64'(exp_hi));
        $display("txn %s op=%0d a=%h b=%h lo=%h hi=%h lat=%0d", tag, op, a, b,
                 ifc16.result, ifc16.result_hi, lat);
        ifc16.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc16.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, lo, hi;
        logic        ov;
        logic [3:0]  op;
        int          seen;

        rst = 1'b1;
        ifc.in_valid = 0; ifc.op = 0; ifc.src1 = 0; ifc.src2 = 0; ifc.cancel = 0; ifc.out_ready = 0;
        ifc16.in_valid = 0; ifc16.op = 0; ifc16.src1 = 0; ifc16.src2 = 0; ifc16.cancel = 0; ifc16.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", 64'(ifc.out_valid), 64'(0));
        check("rst_result", 64'(ifc.result), 64'(0));
        check("rst_result_hi", 64'(ifc.result_hi), 64'(0));
        check("rst_overflow", 64'(ifc.overflow), 64'(0));
        check("rst_busy", 64'(ifc.busy), 64'(0));
        check("rst_in_ready", 64'(ifc.in_ready), 64'(1));

        // Directed cases with hand-derived results
        run32("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b1);
        run32("sub_ovf",  4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b1);
        run32("mul_neg",  4'd12, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
        run32("mulu",     4'd13, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'h0000_0004, 1'b0);
        run32("divu_z",   4'd15, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0);
        run32("div_min",  4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run32("div_neg",  4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run32("div_z_neg",4'd14, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b0);

        // Randomized stimulus against the model
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            model(op, a, b, lo, hi, ov);
            run32($sformatf("rnd%0d", i), op, a, b, lo, hi, ov);
        end

        // Backpressure: AND result held while out_ready=0
        issue32(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00);
        begin
            int lat;
            wait_result32(lat);
            check("bp_lat", 64'(lat), 64'(1));
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(ifc.out_valid), 64'(1));
            check("bp_result", 64'(ifc.result), 64'(32'h00F0_1200));
            check("bp_in_ready", 64'(ifc.in_ready), 64'(0));
        end
        // Handshake and a new XOR request on the same edge
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1; ifc.op = 4'd7; ifc.src1 = 32'hAAAA_5555; ifc.src2 = 32'h0F0F_0F0F;
        #1;
        check("b2b_in_ready", 64'(ifc.in_ready), 64'(1));
        @(posedge clk); #1;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        check("b2b_valid", 64'(ifc.out_valid), 64'(1));
        check("b2b_result", 64'(ifc.result), 64'(32'hA5A5_5A5A));
        $display("txn b2b_xor result=%h", ifc.result);
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;

        // Cancel a DIV at its tenth busy cycle
        issue32(4'd14, 32'hFFFF_FF9C, 32'h0000_0007);
        check("cancel_busy_before", 64'(ifc.busy), 64'(1));
        repeat (9) @(posedge clk);
        #1 ifc.cancel = 1'b1;
        @(posedge clk); #1;
        ifc.cancel = 1'b0;
        check("cancel_busy", 64'(ifc.busy), 64'(0));
        check("cancel_in_ready", 64'(ifc.in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("cancel_no_valid", 64'(seen), 64'(0));
        $display("txn cancel_div busy=%b out_valid_cycles=%0d", ifc.busy, seen);

        // Asynchronous reset in the middle of a MUL
        issue32(4'd12, 32'h0000_0005, 32'h0000_0007);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(ifc.out_valid), 64'(0));
        check("arst_busy", 64'(ifc.busy), 64'(0));
        check("arst_result", 64'(ifc.result), 64'(0));
        check("arst_result_hi", 64'(ifc.result_hi), 64'(0));
        check("arst_overflow", 64'(ifc.overflow), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("arst_in_ready", 64'(ifc.in_ready), 64'(1));
        $display("txn async_reset busy=%b in_ready=%b", ifc.busy, ifc.in_ready);
        run32("post_rst_mul", 4'd12, 32'h0000_0005, 32'h0000_0007, 32'h0000_0023, 32'h0, 1'b0);

        // WIDTH=16 instance
        run16("w16_sra",  4'd10, 16'h0004, 16'h8000, 16'hF800, 16'h0000, 1);
        run16("w16_lui",  4'd11, 16'h1234, 16'h00AB, 16'hAB00, 16'h0000, 1);
        run16("w16_mulu", 4'd13, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 17);
        run16("w16_div",  4'd14, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the advanced CPU execute stage. It extends the single-cycle integer ALU with a WIDTH parameter, a binary-encoded opcode, and a valid/ready handshake on both sides. It adds iterative signed/unsigned multiply and divide, which produce a two-word result. The execute stage stalls on `in_ready`/`out_valid` instead of assuming single-cycle completion.

## Interface
- `WIDTH`, 32, operand/result width.
  - Legal values: 8, 16, 32, 64.
  - Shift amount is `src1[$clog2(WIDTH)-1:0]`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operation request.
- `in_ready` output 1: block can accept a request this cycle.
- `op` input 4: opcode.
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 NOR, 6 OR, 7 XOR
  - 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 MUL, 13 MULU, 14 DIV, 15 DIVU
- `src1` input WIDTH: operand 1. Shift amount for shifts; dividend for DIV/DIVU.
- `src2` input WIDTH: operand 2. Value shifted for shifts; divisor for DIV/DIVU.
- `cancel` input 1: abort the in-flight multi-cycle operation (pipeline flush).
- `out_valid` output 1: result registers hold a completed result.
- `out_ready` input 1: consumer takes the result this cycle.
- `result` output WIDTH: primary result. Product low half or quotient for MUL/DIV ops.
- `result_hi` output WIDTH: product high half or remainder for MUL/DIV ops; 0 for ops 0–11.
- `overflow` output 1: signed overflow; ADD/SUB only, 0 for all other ops.
- `busy` output 1: FSM in BUSY.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready`=1.
  - On accept (`in_valid`): op 0–11 → compute and register outputs, go to DONE.
  - op 12–15 → latch operands, load iteration counter with WIDTH, go to BUSY.
- **BUSY**
  - `in_ready`=0. One iteration per cycle; counter decrements.
  - When the counter reaches 0, register the final result and go to DONE.
- **DONE**
  - `out_valid`=1; outputs stable until handshake.
  - `in_ready` = `out_ready`. A new request in the same cycle as the handshake is accepted, so back-to-back issue is allowed.
  - On handshake: go to IDLE if no new accept, otherwise proceed as for an IDLE accept.
- **Single-cycle ops**
  - ADD/SUB: WIDTH-bit wraparound; `overflow` set on signed overflow.
  - SLT: signed compare → {0…,1/0}. SLTU: unsigned compare → {0…,1/0}.
  - SLL/SRL/SRA: shift src2 by the amount in src1 (see `WIDTH`).
  - LUI: `{src2[WIDTH/2-1:0], WIDTH/2 zeros}`.
- **MUL/MULU**
  - Shift-add over magnitudes, 2·WIDTH-bit product → {`result_hi`, `result`}.
  - MUL negates the product when the operand signs differ.
- **DIV/DIVU**
  - Restoring division over magnitudes.
  - Quotient sign = s1^s2; remainder sign = sign of src1.
- **Divide-by-zero:** quotient all ones, remainder = src1, for both DIV and DIVU.
- **DIV of MIN by −1:** quotient = MIN, remainder = 0.
- Special cases still take the full multi-cycle latency.
- **cancel**
  - In BUSY: next state IDLE; no result produced; `out_valid` stays 0.
  - In IDLE: ignored.
  - In DONE: ignored; the result is already committed.
  - A request presented in the same cycle as cancel in IDLE is accepted normally.
- **Reset (asserted at any time, including mid-BUSY)**
  - State → IDLE, counter → 0.
  - `out_valid`, `result`, `result_hi`, `overflow`, `busy` → 0.
  - `in_ready` = 1 once reset is released.

## Timing
- **Op 0–11:** accepted at edge N → `out_valid`=1 after edge N+1 (latency 1).
- **Op 12–15:** accepted at edge N → BUSY for cycles N+1…N+WIDTH → `out_valid`=1 after edge N+WIDTH+1 (latency WIDTH+1; 33 for WIDTH=32).
- **Throughput**
  - Single-cycle ops: 1 per cycle while `out_ready`=1.
  - Multi-cycle ops: 1 per WIDTH+1 cycles.
- **Handshake rules**
  - Requester holds `op`/`src1`/`src2` stable only during the accept cycle; operands are latched at accept.
  - `out_valid` never deasserts without `out_ready`.
- **Output path:** all outputs are registered except `in_ready`, which is combinational from state and `out_ready`.

## Test plan
- **ADD overflow:** ADD 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `overflow`=1, `out_valid` one cycle after accept. SUB 0x80000000 − 1 → 0x7FFFFFFF, `overflow`=1.
- **Signed multiply:** MUL −3 × 5 (0xFFFFFFFD, 0x00000005) → `result`=0xFFFFFFF1, `result_hi`=0xFFFFFFFF at cycle 33. MULU same operands → `result_hi`=0x00000004, `result`=0xFFFFFFF1.
- **Divide edge cases**
  - DIVU 0x1234 / 0 → `result`=0xFFFFFFFF, `result_hi`=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → `result`=0x80000000, `result_hi`=0.
  - DIV −7 / 2 → `result`=0xFFFFFFFD, `result_hi`=0xFFFFFFFF.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after an AND result → `out_valid` and `result` stable, `in_ready`=0. Then `out_ready`=1 together with a new XOR request → request accepted, next result one cycle later.
- **Cancel and reset:** cancel at BUSY cycle 10 of a DIV → IDLE next cycle, no `out_valid`, `in_ready`=1. Async `rst` pulse mid-MUL → all outputs 0 immediately, IDLE after release.
- **WIDTH=16 instance:** SRA 0x8000 >> 4 → 0xF800. LUI src2=0x00AB → 0xAB00. MULU 0xFFFF × 0xFFFF → hi 0xFFFE, lo 0x0001 at cycle 17.
